// File: rtl/ps2_keypad_rx_if.sv
// rtl/ps2_keypad_rx_if.sv - key-entry read port and status bundle for ps2_keypad_rx
//
// Purpose: carries the key FIFO head, its pop strobe and the receiver status
// flags between the PS/2 receiver and the CPU keyboard cache.
// Signals:
//   key_data  [4:0]  head entry {ctrl, nibble}
//   key_valid        FIFO not empty
//   rd_en            single-cycle pop strobe from the consumer
//   overflow         sticky dropped-key flag
//   frame_err        one-cycle bad/aborted frame pulse
// Modports: master = receiver side, slave = consumer side.
interface ps2_keypad_rx_if;
  logic [4:0] key_data;
  logic       key_valid;
  logic       rd_en;
  logic       overflow;
  logic       frame_err;

  modport master (output key_data, key_valid, overflow, frame_err, input rd_en);
  modport slave  (input key_data, key_valid, overflow, frame_err, output rd_en);
endinterface

// File: rtl/ps2_keypad_rx.sv
// rtl/ps2_keypad_rx.sv - PS/2 keyboard receiver producing hex/control key entries
//
// Purpose: deframes PS/2 bytes, handles F0/E0 prefixes, suppresses typematic
// repeats, maps make codes to 5-bit key entries and queues them in a
// show-ahead FIFO that the CPU pops with a single-cycle strobe.
// Ports:
//   clk       CPU clock, all logic on rising edge
//   rstn      asynchronous active-low reset
//   ps2_clk   raw PS/2 clock (asynchronous)
//   ps2_data  raw PS/2 data (asynchronous)
//   kbd       ps2_keypad_rx_if.master: key_data, key_valid, rd_en, overflow, frame_err
module ps2_keypad_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_keypad_rx_if.master  kbd
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------- input conditioning
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_s;
  logic             dat_s;
  logic             flt_lvl;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_flip;
  logic             sample_evt;

  // Synchronizers reset high so an idle line does not look like a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign flt_flip   = (clk_s != flt_lvl) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
  assign sample_evt = flt_flip && flt_lvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flt_lvl <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      flt_lvl <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- frame FSM
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state, state_d;
  logic [7:0]       shreg, shreg_d;
  logic [2:0]       bitcnt, bitcnt_d;
  logic             par_bit, par_bit_d;
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout;
  logic             frame_ok;
  logic             err_det;

  assign timeout = (state != S_IDLE) && !sample_evt &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bitcnt_d  = bitcnt;
    par_bit_d = par_bit;
    frame_ok  = 1'b0;
    err_det   = 1'b0;
    if (timeout) begin
      state_d = S_IDLE;
      err_det = 1'b1;
    end else if (sample_evt) begin
      case (state)
        S_IDLE: begin
          if (!dat_s) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shreg_d  = {dat_s, shreg[7:1]};
          bitcnt_d = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_bit_d = dat_s;
          state_d   = S_STOP;
        end
        S_STOP: begin
          // Odd parity: data plus parity bit must carry an odd number of ones.
          if (dat_s && (^{shreg, par_bit})) frame_ok = 1'b1;
          else                              err_det  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- byte layer
  logic       brk, brk_d;
  logic [7:0] last_make, last_make_d;
  logic       push;
  logic [5:0] map_res;

  // Returns {hit, key}; hit=0 for codes that produce no entry.
  function automatic logic [5:0] map_code(input logic [7:0] code);
    case (code)
      8'h45: map_code = 6'h20;
      8'h16: map_code = 6'h21;
      8'h1E: map_code = 6'h22;
      8'h26: map_code = 6'h23;
      8'h25: map_code = 6'h24;
      8'h2E: map_code = 6'h25;
      8'h36: map_code = 6'h26;
      8'h3D: map_code = 6'h27;
      8'h3E: map_code = 6'h28;
      8'h46: map_code = 6'h29;
      8'h1C: map_code = 6'h2A;
      8'h32: map_code = 6'h2B;
      8'h21: map_code = 6'h2C;
      8'h23: map_code = 6'h2D;
      8'h24: map_code = 6'h2E;
      8'h2B: map_code = 6'h2F;
      8'h5A: map_code = 6'h30;
      8'h66: map_code = 6'h31;
      default: map_code = 6'h00;
    endcase
  endfunction

  assign map_res = map_code(shreg);

  always_comb begin
    brk_d       = brk;
    last_make_d = last_make;
    push        = 1'b0;
    if (frame_ok) begin
      if (shreg == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shreg != 8'hE0) begin
        if (brk) begin
          // Releasing the held key re-arms it so the next press is a new make.
          brk_d = 1'b0;
          if (shreg == last_make) last_make_d = 8'h00;
        end else if (shreg != last_make) begin
          push        = map_res[5];
          last_make_d = shreg;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      brk       <= 1'b0;
      last_make <= 8'h00;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bitcnt    <= bitcnt_d;
      par_bit   <= par_bit_d;
      brk       <= brk_d;
      last_make <= last_make_d;
      if (state == S_IDLE || sample_evt || timeout) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- key FIFO
  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, pop, do_push, drop;
  logic             overflow_q;
  logic             frame_err_q;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = kbd.rd_en && !empty;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= map_res[4:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= err_det;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)     overflow_q <= 1'b1;
      else if (pop) overflow_q <= 1'b0;
    end
  end

  // Head is gated so key_data reads zero whenever nothing is queued.
  assign kbd.key_valid = !empty;
  assign kbd.key_data  = empty ? 5'h00 : mem[rd_ptr];
  assign kbd.overflow  = overflow_q;
  assign kbd.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// tb/tb_ps2_keypad_rx.sv - directed self-checking bench for ps2_keypad_rx
module tb_ps2_keypad_rx;
  logic clk      = 1'b0;
  logic rstn     = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   err_cnt  = 0;
  int   err0;

  ps2_keypad_rx_if kbd ();

  ps2_keypad_rx #(
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(20000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .kbd(kbd)
  );

  always #5 clk = ~clk;

  // Counts cycles with frame_err high; a clean single pulse adds exactly one.
  always @(negedge clk) if (kbd.frame_err === 1'b1) err_cnt = err_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends frame bits LSB first; pop_stop raises rd_en on the stop-bit sample edge
  // (2 sync + FILTER_LEN cycles after the ps2_clk fall).
  task automatic send_bits(input logic [10:0] frm, input int nbits, input bit pop_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frm[i];
      idle(10);
      ps2_clk = 1'b0;
      if (pop_stop && i == 10) begin
        idle(5);
        kbd.rd_en = 1'b1;
        idle(1);
        kbd.rd_en = 1'b0;
        idle(14);
      end else begin
        idle(20);
      end
      ps2_clk = 1'b1;
      idle(10);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip, input bit pop_stop);
    logic par;
    par = (~^b) ^ flip;
    send_bits({1'b1, par, b, 1'b0}, 11, pop_stop);
    idle(5);
  endtask

  task automatic pop_one();
    kbd.rd_en = 1'b1;
    idle(1);
    kbd.rd_en = 1'b0;
    idle(1);
  endtask

  initial begin
    kbd.rd_en = 1'b0;
    idle(3);
    check("rst_valid", 32'(kbd.key_valid), 0);
    check("rst_data", 32'(kbd.key_data), 0);
    check("rst_ovf", 32'(kbd.overflow), 0);
    check("rst_ferr", 32'(kbd.frame_err), 0);
    rstn = 1'b1;
    idle(5);

    // Single key 0x16 -> 1
    send_byte(8'h16, 0, 0);
    check("k16_valid", 32'(kbd.key_valid), 1);
    check("k16_data", 32'(kbd.key_data), 32'h01);
    pop_one();
    check("k16_pop_valid", 32'(kbd.key_valid), 0);

    // Typematic suppression and break handling
    send_byte(8'h1E, 0, 0);
    send_byte(8'h1E, 0, 0);
    send_byte(8'h1E, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1E, 0, 0);
    send_byte(8'h1E, 0, 0);
    check("rep_data0", 32'(kbd.key_data), 32'h02);
    pop_one();
    check("rep_valid1", 32'(kbd.key_valid), 1);
    check("rep_data1", 32'(kbd.key_data), 32'h02);
    pop_one();
    check("rep_empty", 32'(kbd.key_valid), 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h16, 0, 0);
    check("brk16_empty", 32'(kbd.key_valid), 0);

    // Parity error
    err0 = err_cnt;
    send_byte(8'h16, 1, 0);
    check("par_err_pulse", 32'(err_cnt - err0), 1);
    check("par_no_entry", 32'(kbd.key_valid), 0);
    send_byte(8'h5A, 0, 0);
    check("enter_data", 32'(kbd.key_data), 32'h10);
    pop_one();

    // Timeout on partial frame
    err0 = err_cnt;
    send_bits({1'b1, 1'b0, 8'h0F, 1'b0}, 5, 0);
    ps2_data = 1'b1;
    idle(20100);
    check("tmo_pulse", 32'(err_cnt - err0), 1);
    check("tmo_no_entry", 32'(kbd.key_valid), 0);
    send_byte(8'h66, 0, 0);
    check("bksp_data", 32'(kbd.key_data), 32'h11);
    check("bksp_valid", 32'(kbd.key_valid), 1);
    pop_one();

    // Overflow and simultaneous pop/push at full
    send_byte(8'h45, 0, 0);
    send_byte(8'h16, 0, 0);
    send_byte(8'h1E, 0, 0);
    send_byte(8'h26, 0, 0);
    send_byte(8'h25, 0, 0);
    check("full_head", 32'(kbd.key_data), 32'h00);
    check("ovf_set", 32'(kbd.overflow), 1);
    pop_one();
    check("pop_head1", 32'(kbd.key_data), 32'h01);
    check("ovf_clr", 32'(kbd.overflow), 0);
    send_byte(8'h2E, 0, 0);
    check("refill_ovf", 32'(kbd.overflow), 0);
    send_byte(8'h36, 0, 1);
    check("pp_ovf", 32'(kbd.overflow), 0);
    check("pp_head", 32'(kbd.key_data), 32'h02);
    pop_one();
    check("pp_e1", 32'(kbd.key_data), 32'h03);
    pop_one();
    check("pp_e2", 32'(kbd.key_data), 32'h05);
    pop_one();
    check("pp_e3", 32'(kbd.key_data), 32'h06);
    check("pp_e3_valid", 32'(kbd.key_valid), 1);
    pop_one();
    check("pp_empty", 32'(kbd.key_valid), 0);

    // Reset mid-frame with entries queued
    send_byte(8'h16, 0, 0);
    send_byte(8'h1E, 0, 0);
    check("pre_rst_valid", 32'(kbd.key_valid), 1);
    send_bits({1'b1, 1'b0, 8'h2B, 1'b0}, 3, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(kbd.key_valid), 0);
    check("mid_rst_data", 32'(kbd.key_data), 0);
    check("mid_rst_ovf", 32'(kbd.overflow), 0);
    check("mid_rst_ferr", 32'(kbd.frame_err), 0);
    err0 = err_cnt;
    ps2_data = 1'b1;
    idle(5);
    rstn = 1'b1;
    idle(50);
    check("rst_no_ferr", 32'(err_cnt - err0), 0);
    send_byte(8'h2B, 0, 0);
    check("post_rst_data", 32'(kbd.key_data), 32'h0F);
    check("post_rst_valid", 32'(kbd.key_valid), 1);
    pop_one();
    check("post_rst_empty", 32'(kbd.key_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
